aclk_time_counter: RTL and testbench

//  Consumer end of the alarm-clock tick interface. Counts one_minute pulses into a BCD HH:MM time-of-day.

---
 rtl/aclk_time_counter_if.sv | 30 +++
 rtl/aclk_time_counter.sv | 109 ++++++++++
 tb/tb_aclk_time_counter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/aclk_time_counter_if.sv
// Tick/key-path interface between the tick generator, set logic and the time counter.
// The master drives tick and load requests; the slave (counter) returns time and load status.
interface aclk_time_counter_if;
    logic       one_minute;
    logic       load_new_c;
    logic [3:0] new_ms_hr;
    logic [3:0] new_ls_hr;
    logic [3:0] new_ms_min;
    logic [3:0] new_ls_min;
    logic       new_pm;
    logic [3:0] current_ms_hr;
    logic [3:0] current_ls_hr;
    logic [3:0] current_ms_min;
    logic [3:0] current_ls_min;
    logic       pm;
    logic       reset_count;
    logic       load_err;

    modport master (
        output one_minute, load_new_c, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_pm,
        input  current_ms_hr, current_ls_hr, current_ms_min, current_ls_min, pm,
               reset_count, load_err
    );

    modport slave (
        input  one_minute, load_new_c, new_ms_hr, new_ls_hr, new_ms_min, new_ls_min, new_pm,
        output current_ms_hr, current_ls_hr, current_ms_min, current_ls_min, pm,
               reset_count, load_err
    );
endinterface

// File: rtl/aclk_time_counter.sv
// BCD HH:MM time-of-day counter advanced by one_minute pulses, with validated time load.
// Priority per edge: reset > load > tick; a tick coinciding with a load is dropped.
module aclk_time_counter #(
    parameter int unsigned TWELVE_HR = 0
) (
    input logic           clk,
    input logic           reset,
    aclk_time_counter_if.slave bus
);
    localparam bit H12 = (TWELVE_HR != 0);

    logic [3:0] ms_hr_q, ms_hr_d;
    logic [3:0] ls_hr_q, ls_hr_d;
    logic [3:0] ms_min_q, ms_min_d;
    logic [3:0] ls_min_q, ls_min_d;
    logic       pm_q, pm_d;
    logic       rc_q, rc_d;
    logic       err_q, err_d;
    logic       load_ok;
    logic       hr_ok;

    always_comb begin
        if (H12) begin
            hr_ok = ((bus.new_ms_hr == 4'd0) && (bus.new_ls_hr >= 4'd1) && (bus.new_ls_hr <= 4'd9)) ||
                    ((bus.new_ms_hr == 4'd1) && (bus.new_ls_hr <= 4'd2));
        end else begin
            hr_ok = (bus.new_ms_hr <= 4'd2) && (bus.new_ls_hr <= 4'd9) &&
                    !((bus.new_ms_hr == 4'd2) && (bus.new_ls_hr > 4'd3));
        end
        load_ok = hr_ok && (bus.new_ms_min <= 4'd5) && (bus.new_ls_min <= 4'd9);
    end

    always_comb begin
        ms_hr_d  = ms_hr_q;
        ls_hr_d  = ls_hr_q;
        ms_min_d = ms_min_q;
        ls_min_d = ls_min_q;
        pm_d     = pm_q;
        rc_d     = 1'b0;
        err_d    = 1'b0;
        if (bus.load_new_c) begin
            if (load_ok) begin
                ms_hr_d  = bus.new_ms_hr;
                ls_hr_d  = bus.new_ls_hr;
                ms_min_d = bus.new_ms_min;
                ls_min_d = bus.new_ls_min;
                pm_d     = H12 ? bus.new_pm : 1'b0;
                rc_d     = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.one_minute) begin
            if (ls_min_q != 4'd9) begin
                ls_min_d = ls_min_q + 4'd1;
            end else begin
                ls_min_d = 4'd0;
                if (ms_min_q != 4'd5) begin
                    ms_min_d = ms_min_q + 4'd1;
                end else begin
                    ms_min_d = 4'd0;
                    // Hour carry: 12h wraps 12->01 and toggles pm on 11->12; 24h wraps 23->00.
                    if (H12 && (ms_hr_q == 4'd1) && (ls_hr_q == 4'd2)) begin
                        ms_hr_d = 4'd0;
                        ls_hr_d = 4'd1;
                    end else if (H12 && (ms_hr_q == 4'd1) && (ls_hr_q == 4'd1)) begin
                        ls_hr_d = 4'd2;
                        pm_d    = ~pm_q;
                    end else if (!H12 && (ms_hr_q == 4'd2) && (ls_hr_q == 4'd3)) begin
                        ms_hr_d = 4'd0;
                        ls_hr_d = 4'd0;
                    end else if (ls_hr_q == 4'd9) begin
                        ms_hr_d = ms_hr_q + 4'd1;
                        ls_hr_d = 4'd0;
                    end else begin
                        ls_hr_d = ls_hr_q + 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_hr_q  <= H12 ? 4'd1 : 4'd0;
            ls_hr_q  <= H12 ? 4'd2 : 4'd0;
            ms_min_q <= '0;
            ls_min_q <= '0;
            pm_q     <= 1'b0;
            rc_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ms_hr_q  <= ms_hr_d;
            ls_hr_q  <= ls_hr_d;
            ms_min_q <= ms_min_d;
            ls_min_q <= ls_min_d;
            pm_q     <= pm_d;
            rc_q     <= rc_d;
            err_q    <= err_d;
        end
    end

    assign bus.current_ms_hr  = ms_hr_q;
    assign bus.current_ls_hr  = ls_hr_q;
    assign bus.current_ms_min = ms_min_q;
    assign bus.current_ls_min = ls_min_q;
    assign bus.pm             = H12 ? pm_q : 1'b0;
    assign bus.reset_count    = rc_q;
    assign bus.load_err       = err_q;
endmodule

// File: tb/tb_aclk_time_counter.sv
// Scoreboard bench for aclk_time_counter in 24-hour and 12-hour builds.
// The driver queues hand-computed expectations; a negedge monitor pops and compares.
module tb_aclk_time_counter;
    logic clk;
    logic rst24, rst12;
    int   checks = 0;
    int   passed = 0;

    aclk_time_counter_if if24 ();
    aclk_time_counter_if if12 ();

    aclk_time_counter #(.TWELVE_HR(0)) dut24 (.clk(clk), .reset(rst24), .bus(if24));
    aclk_time_counter #(.TWELVE_HR(1)) dut12 (.clk(clk), .reset(rst12), .bus(if12));

    typedef struct {
        bit          sel;
        logic [15:0] t;
        logic        pm;
        logic        rc;
        logic        err;
        string       name;
    } exp_t;

    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rst24 = 1'b0; if24.one_minute = 1'b0; if24.load_new_c = 1'b0; if24.new_pm = 1'b0;
        rst12 = 1'b0; if12.one_minute = 1'b0; if12.load_new_c = 1'b0; if12.new_pm = 1'b0;
        {if24.new_ms_hr, if24.new_ls_hr, if24.new_ms_min, if24.new_ls_min} = '0;
        {if12.new_ms_hr, if12.new_ls_hr, if12.new_ms_min, if12.new_ls_min} = '0;
    endtask

    // One clock of stimulus; expectation describes outputs after this edge.
    task automatic step(input bit sel, input bit rst, input bit tick, input bit ld,
                        input logic [15:0] lt, input bit lpm,
                        input logic [15:0] et, input bit epm, input bit erc, input bit eerr,
                        input string name);
        exp_t e;
        if (sel) begin
            rst12 = rst; if12.one_minute = tick; if12.load_new_c = ld; if12.new_pm = lpm;
            {if12.new_ms_hr, if12.new_ls_hr, if12.new_ms_min, if12.new_ls_min} = lt;
        end else begin
            rst24 = rst; if24.one_minute = tick; if24.load_new_c = ld; if24.new_pm = lpm;
            {if24.new_ms_hr, if24.new_ls_hr, if24.new_ms_min, if24.new_ls_min} = lt;
        end
        @(posedge clk);
        e.sel = sel; e.t = et; e.pm = epm; e.rc = erc; e.err = eerr; e.name = name;
        q.push_back(e);
        #1;
        idle();
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [18:0] act;
        logic [18:0] req;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel)
                act = {if12.current_ms_hr, if12.current_ls_hr, if12.current_ms_min,
                       if12.current_ls_min, if12.pm, if12.reset_count, if12.load_err};
            else
                act = {if24.current_ms_hr, if24.current_ls_hr, if24.current_ms_min,
                       if24.current_ls_min, if24.pm, if24.reset_count, if24.load_err};
            req = {e.t, e.pm, e.rc, e.err};
            checks++;
            if (act === req) passed++;
            else $display("FAIL %s: got time=%h pm/rc/err=%b, want time=%h pm/rc/err=%b",
                          e.name, act[18:3], act[2:0], req[18:3], req[2:0]);
        end
    end

    initial begin
        idle();
        // sel rst tk ld  load     lpm  exp      pm rc er
        step(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "rst24");
        step(0, 0, 0, 1, 16'h1437, 0, 16'h1437, 0, 1, 0, "ld24_1437");
        step(0, 0, 1, 0, 16'h0000, 0, 16'h1438, 0, 0, 0, "tick_1438");
        step(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "rst24_mid");
        step(0, 0, 0, 1, 16'h2358, 0, 16'h2358, 0, 1, 0, "ld_2358");
        step(0, 0, 1, 0, 16'h0000, 0, 16'h2359, 0, 0, 0, "tick_2359");
        step(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "wrap_0000");
        step(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, "idle24");
        step(0, 0, 0, 1, 16'h0959, 0, 16'h0959, 0, 1, 0, "ld_0959");
        step(0, 0, 1, 0, 16'h0000, 0, 16'h1000, 0, 0, 0, "tick_1000");
        step(0, 0, 0, 1, 16'h1959, 0, 16'h1959, 0, 1, 0, "ld_1959");
        step(0, 0, 1, 0, 16'h0000, 0, 16'h2000, 0, 0, 0, "tick_2000");
        step(0, 0, 0, 1, 16'h1259, 0, 16'h1259, 0, 1, 0, "ld_1259_24");
        step(0, 0, 1, 0, 16'h0000, 0, 16'h1300, 0, 0, 0, "tick_1300");
        step(0, 0, 0, 1, 16'h2400, 0, 16'h1300, 0, 0, 1, "bad_2400");
        step(0, 0, 0, 1, 16'h0760, 0, 16'h1300, 0, 0, 1, "bad_0760");
        step(0, 0, 0, 1, 16'h1A00, 0, 16'h1300, 0, 0, 1, "bad_1A00");
        step(0, 0, 0, 0, 16'h0000, 0, 16'h1300, 0, 0, 0, "err_clear");
        step(0, 0, 1, 1, 16'h0505, 1, 16'h0505, 0, 1, 0, "ld_tick_drop");
        step(0, 0, 1, 0, 16'h0000, 0, 16'h0506, 0, 0, 0, "tick_0506");
        step(0, 0, 0, 1, 16'h0100, 0, 16'h0100, 0, 1, 0, "hold_ld_1");
        step(0, 0, 0, 1, 16'h0200, 0, 16'h0200, 0, 1, 0, "hold_ld_2");
        step(0, 1, 0, 1, 16'h0300, 0, 16'h0000, 0, 0, 0, "rst_over_ld");
        step(0, 0, 0, 1, 16'h0009, 0, 16'h0009, 0, 1, 0, "ld_0009");
        step(0, 0, 1, 0, 16'h0000, 0, 16'h0010, 0, 0, 0, "tick_0010");
        step(0, 0, 1, 0, 16'h0000, 0, 16'h0011, 0, 0, 0, "tick_0011");

        step(1, 1, 0, 0, 16'h0000, 0, 16'h1200, 0, 0, 0, "rst12");
        step(1, 0, 0, 1, 16'h1437, 0, 16'h1200, 0, 0, 1, "bad12_1437");
        step(1, 0, 0, 1, 16'h1037, 1, 16'h1037, 1, 1, 0, "ld12_1037p");
        step(1, 1, 1, 0, 16'h0000, 0, 16'h1200, 0, 0, 0, "rst12_mid");
        step(1, 0, 0, 1, 16'h1159, 0, 16'h1159, 0, 1, 0, "ld_1159a");
        step(1, 0, 1, 0, 16'h0000, 0, 16'h1200, 1, 0, 0, "tick_1200p");
        step(1, 0, 0, 1, 16'h1259, 1, 16'h1259, 1, 1, 0, "ld_1259p");
        step(1, 0, 1, 0, 16'h0000, 0, 16'h0100, 1, 0, 0, "tick_0100p");
        step(1, 0, 0, 1, 16'h0030, 0, 16'h0100, 1, 0, 1, "bad12_0030");
        step(1, 0, 0, 1, 16'h0959, 0, 16'h0959, 0, 1, 0, "ld12_0959");
        step(1, 0, 1, 0, 16'h0000, 0, 16'h1000, 0, 0, 0, "tick12_1000");
        step(1, 0, 0, 1, 16'h1159, 1, 16'h1159, 1, 1, 0, "ld_1159p");
        step(1, 0, 1, 0, 16'h0000, 0, 16'h1200, 0, 0, 0, "tick_1200a");

        for (int unsigned i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
